// File: rtl/l1i_cache_pkg.sv
// Purpose: shared widths, bundle type and address-field positions for the L1 instruction cache.
// Latency: n/a (types, constants and a combinational bundle-extract helper).
// Backpressure: n/a.
package l1i_cache_pkg;

    localparam int FETCH_ADDR_W = 64;
    localparam int LINE_W       = 512;
    localparam int INST_W       = 32;
    localparam int OFFSET_W     = 6;
    localparam int INDEX_W      = 8;
    localparam int TAG_W        = FETCH_ADDR_W - INDEX_W - OFFSET_W;
    localparam int PID_W        = 20;
    localparam int TID_W        = 16;
    localparam int ICNT_W       = 64;
    localparam int NUM_LINES    = 1 << INDEX_W;
    localparam int BUNDLE_W     = 4 * INST_W;

    // Address fields are numbered big-endian (bit 0 = MSB); these are the little-endian LSBs.
    localparam int WORD_LSB  = 2;   // addr[60:61]
    localparam int BSEL_LSB  = 4;   // addr[58:59]
    localparam int INDEX_LSB = 6;   // addr[50:57]
    localparam int TAG_LSB   = 14;  // addr[0:49]

    typedef logic [BUNDLE_W-1:0] bundle_t;

    // Instruction 0 of the line and of the bundle sits in the most significant bits.
    function automatic bundle_t extractBundle(input logic [LINE_W-1:0] line,
                                              input logic [1:0] bsel,
                                              input logic [1:0] word);
        bundle_t b;
        int k;
        b = '0;
        for (int i = 0; i < 4; i++) begin
            if (int'(word) + i < 4) begin
                k = 4 * int'(bsel) + int'(word) + i;
                b[BUNDLE_W-1-INST_W*i -: INST_W] = line[LINE_W-1-INST_W*k -: INST_W];
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/l1i_line_array.sv
// Purpose: direct-mapped tag/valid/data store, one async read port and one sync write port.
// Latency: read is combinational, so a same-cycle write is seen only from the next cycle.
// Backpressure: none; a write is accepted on every cycle wrEn is high.
module l1i_line_array
    import l1i_cache_pkg::*;
(
    input  logic               clk,
    input  logic               rstN,
    input  logic [INDEX_W-1:0] rdIndex,
    output logic               rdValid,
    output logic [TAG_W-1:0]   rdTag,
    output logic [LINE_W-1:0]  rdLine,
`ifdef L1I_PID_TID_CHECK_EN
    output logic [PID_W-1:0]   rdPid,
    output logic [TID_W-1:0]   rdTid,
    input  logic [PID_W-1:0]   wrPid,
    input  logic [TID_W-1:0]   wrTid,
`endif
    input  logic               wrEn,
    input  logic [INDEX_W-1:0] wrIndex,
    input  logic [TAG_W-1:0]   wrTag,
    input  logic [LINE_W-1:0]  wrLine
);

    logic [NUM_LINES-1:0] validQ;
    logic [TAG_W-1:0]     tagMem  [NUM_LINES];
    logic [LINE_W-1:0]    dataMem [NUM_LINES];

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            validQ <= '0;
        end else if (wrEn) begin
            validQ[wrIndex] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) begin
            tagMem[wrIndex]  <= wrTag;
            dataMem[wrIndex] <= wrLine;
        end
    end

    assign rdValid = validQ[rdIndex];
    assign rdTag   = tagMem[rdIndex];
    assign rdLine  = dataMem[rdIndex];

`ifdef L1I_PID_TID_CHECK_EN
    logic [PID_W-1:0] pidMem [NUM_LINES];
    logic [TID_W-1:0] tidMem [NUM_LINES];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            pidMem[wrIndex] <= wrPid;
            tidMem[wrIndex] <= wrTid;
        end
    end

    assign rdPid = pidMem[rdIndex];
    assign rdTid = tidMem[rdIndex];
`endif

endmodule

// File: rtl/l1i_cache.sv
// Purpose: direct-mapped L1 I-cache returning up to 4-instruction bundles; L1I_PID_TID_CHECK_EN adds Pid/Tid to the hit test.
// Latency: one cycle from fetch to registered bundle or miss report.
// Backpressure: fetchStall_i freezes all outputs; a pending miss blocks fetches until a matching cacheUpdate_i.
module l1i_cache
    import l1i_cache_pkg::*;
#(
    parameter int fetchingAddressWidth    = FETCH_ADDR_W,
    parameter int cacheLineWith           = LINE_W,
    parameter int instructionWidth        = INST_W,
    parameter int offsetWidth             = OFFSET_W,
    parameter int indexWidth              = INDEX_W,
    parameter int tagWidth                = fetchingAddressWidth - indexWidth - offsetWidth,
    parameter int PidSize                 = PID_W,
    parameter int TidSize                 = TID_W,
    parameter int instructionCounterWidth = ICNT_W
) (
    input  logic                                clock_i,
    input  logic                                cacheReset_i,
    input  logic                                fetchEnable_i,
    input  logic                                fetchStall_i,
    input  logic [PidSize-1:0]                  Pid_i,
    input  logic [TidSize-1:0]                  Tid_i,
    input  logic [fetchingAddressWidth-1:0]     fetchAddress_i,
    input  logic                                cacheUpdate_i,
    input  logic [fetchingAddressWidth-1:0]     cacheUpdateAddress_i,
    input  logic [PidSize-1:0]                  cacheUpdatePid_i,
    input  logic [TidSize-1:0]                  cacheUpdateTid_i,
    input  logic [instructionCounterWidth-1:0]  missedInstMajorId_i,
    input  logic [cacheLineWith-1:0]            cacheUpdateLine_i,
    input  logic                                naturalWriteEn_i,
    input  logic [fetchingAddressWidth-1:0]     naturalWriteAddress_i,
    input  logic [cacheLineWith-1:0]            naturalWriteLine_i,
    input  logic [PidSize-1:0]                  naturalPid_i,
    input  logic [TidSize-1:0]                  naturalTid_i,
    output logic                                outputEnable_o,
    output logic [4*instructionWidth-1:0]       outputBundle_o,
    output logic [fetchingAddressWidth-1:0]     bundleAddress_o,
    output logic [1:0]                          bundleLen_o,
    output logic [PidSize-1:0]                  bundlePid_o,
    output logic [TidSize-1:0]                  bundleTid_o,
    output logic [instructionCounterWidth-1:0]  bundleStartMajId_o,
    output logic                                cacheMiss_o,
    output logic [fetchingAddressWidth-1:0]     missedAddress_o,
    output logic [instructionCounterWidth-1:0]  missedInstMajorId_o,
    output logic [PidSize-1:0]                  missedPid_o,
    output logic [TidSize-1:0]                  missedTid_o
);

    logic [indexWidth-1:0] fetchIndex;
    logic [tagWidth-1:0]   fetchTag;
    logic [1:0]            fetchBsel;
    logic [1:0]            fetchWord;
    logic [1:0]            fetchLen;
    logic [instructionCounterWidth-1:0] fetchCount;

    assign fetchIndex = fetchAddress_i[offsetWidth +: indexWidth];
    assign fetchTag   = fetchAddress_i[offsetWidth+indexWidth +: tagWidth];
    assign fetchBsel  = fetchAddress_i[BSEL_LSB +: 2];
    assign fetchWord  = fetchAddress_i[WORD_LSB +: 2];
    assign fetchLen   = ~fetchWord;
    assign fetchCount = instructionCounterWidth'(fetchLen) + instructionCounterWidth'(1);

    // The fill strobe owns the single write port; a coincident natural write is dropped.
    logic                     wrEn;
    logic [indexWidth-1:0]    wrIndex;
    logic [tagWidth-1:0]      wrTag;
    logic [cacheLineWith-1:0] wrLine;
    logic [fetchingAddressWidth-1:0] wrAddr;

    assign wrEn    = cacheUpdate_i | naturalWriteEn_i;
    assign wrAddr  = cacheUpdate_i ? cacheUpdateAddress_i : naturalWriteAddress_i;
    assign wrLine  = cacheUpdate_i ? cacheUpdateLine_i : naturalWriteLine_i;
    assign wrIndex = wrAddr[offsetWidth +: indexWidth];
    assign wrTag   = wrAddr[offsetWidth+indexWidth +: tagWidth];

    logic                     rdValid;
    logic [tagWidth-1:0]      rdTag;
    logic [cacheLineWith-1:0] rdLine;
    logic                     hit;

`ifdef L1I_PID_TID_CHECK_EN
    logic [PidSize-1:0] rdPid;
    logic [TidSize-1:0] rdTid;
    logic [PidSize-1:0] wrPid;
    logic [TidSize-1:0] wrTid;

    assign wrPid = cacheUpdate_i ? cacheUpdatePid_i : naturalPid_i;
    assign wrTid = cacheUpdate_i ? cacheUpdateTid_i : naturalTid_i;
    assign hit   = rdValid && (rdTag == fetchTag) && (rdPid == Pid_i) && (rdTid == Tid_i);
`else
    assign hit   = rdValid && (rdTag == fetchTag);
`endif

    logic unusedBits;
    assign unusedBits = ^{cacheUpdateAddress_i[offsetWidth-1:0], naturalWriteAddress_i[offsetWidth-1:0],
                          cacheUpdatePid_i, cacheUpdateTid_i, naturalPid_i, naturalTid_i};

    l1i_line_array u_lineArray (
        .clk     (clock_i),
        .rstN    (cacheReset_i),
        .rdIndex (fetchIndex),
        .rdValid (rdValid),
        .rdTag   (rdTag),
        .rdLine  (rdLine),
`ifdef L1I_PID_TID_CHECK_EN
        .rdPid   (rdPid),
        .rdTid   (rdTid),
        .wrPid   (wrPid),
        .wrTid   (wrTid),
`endif
        .wrEn    (wrEn),
        .wrIndex (wrIndex),
        .wrTag   (wrTag),
        .wrLine  (wrLine)
    );

    logic [instructionCounterWidth-1:0] idCounter;
    logic updMatchesMiss;

    assign updMatchesMiss = cacheUpdateAddress_i[fetchingAddressWidth-1:offsetWidth]
                         == missedAddress_o[fetchingAddressWidth-1:offsetWidth];

    always_ff @(posedge clock_i or negedge cacheReset_i) begin
        if (!cacheReset_i) begin
            idCounter           <= '0;
            outputEnable_o      <= 1'b0;
            outputBundle_o      <= '0;
            bundleAddress_o     <= '0;
            bundleLen_o         <= '0;
            bundlePid_o         <= '0;
            bundleTid_o         <= '0;
            bundleStartMajId_o  <= '0;
            cacheMiss_o         <= 1'b0;
            missedAddress_o     <= '0;
            missedInstMajorId_o <= '0;
            missedPid_o         <= '0;
            missedTid_o         <= '0;
        end else begin
            if (cacheUpdate_i) begin
                idCounter <= missedInstMajorId_i;
                if (cacheMiss_o && updMatchesMiss) begin
                    cacheMiss_o <= 1'b0;
                end
            end
            if (!fetchStall_i) begin
                if (fetchEnable_i && !cacheMiss_o) begin
                    if (hit) begin
                        outputEnable_o     <= 1'b1;
                        outputBundle_o     <= extractBundle(rdLine, fetchBsel, fetchWord);
                        bundleAddress_o    <= fetchAddress_i;
                        bundleLen_o        <= fetchLen;
                        bundlePid_o        <= Pid_i;
                        bundleTid_o        <= Tid_i;
                        bundleStartMajId_o <= idCounter;
                        if (!cacheUpdate_i) begin
                            idCounter <= idCounter + fetchCount;
                        end
                    end else begin
                        outputEnable_o      <= 1'b0;
                        cacheMiss_o         <= 1'b1;
                        missedAddress_o     <= fetchAddress_i;
                        missedInstMajorId_o <= idCounter;
                        missedPid_o         <= Pid_i;
                        missedTid_o         <= Tid_i;
                    end
                end else begin
                    outputEnable_o <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_l1i_cache.sv
// Bench for l1i_cache: directed scenarios plus a randomized run against a direct-mapped cache model.
module tb_l1i_cache;

    logic          clock_i = 1'b0;
    logic          cacheReset_i;
    logic          fetchEnable_i, fetchStall_i;
    logic [19:0]   Pid_i;
    logic [15:0]   Tid_i;
    logic [63:0]   fetchAddress_i;
    logic          cacheUpdate_i;
    logic [63:0]   cacheUpdateAddress_i;
    logic [19:0]   cacheUpdatePid_i;
    logic [15:0]   cacheUpdateTid_i;
    logic [63:0]   missedInstMajorId_i;
    logic [511:0]  cacheUpdateLine_i;
    logic          naturalWriteEn_i;
    logic [63:0]   naturalWriteAddress_i;
    logic [511:0]  naturalWriteLine_i;
    logic [19:0]   naturalPid_i;
    logic [15:0]   naturalTid_i;
    logic          outputEnable_o;
    logic [127:0]  outputBundle_o;
    logic [63:0]   bundleAddress_o;
    logic [1:0]    bundleLen_o;
    logic [19:0]   bundlePid_o;
    logic [15:0]   bundleTid_o;
    logic [63:0]   bundleStartMajId_o;
    logic          cacheMiss_o;
    logic [63:0]   missedAddress_o;
    logic [63:0]   missedInstMajorId_o;
    logic [19:0]   missedPid_o;
    logic [15:0]   missedTid_o;

    always #5 clock_i = ~clock_i;

    l1i_cache dut (
        .clock_i(clock_i), .cacheReset_i(cacheReset_i),
        .fetchEnable_i(fetchEnable_i), .fetchStall_i(fetchStall_i),
        .Pid_i(Pid_i), .Tid_i(Tid_i), .fetchAddress_i(fetchAddress_i),
        .cacheUpdate_i(cacheUpdate_i), .cacheUpdateAddress_i(cacheUpdateAddress_i),
        .cacheUpdatePid_i(cacheUpdatePid_i), .cacheUpdateTid_i(cacheUpdateTid_i),
        .missedInstMajorId_i(missedInstMajorId_i), .cacheUpdateLine_i(cacheUpdateLine_i),
        .naturalWriteEn_i(naturalWriteEn_i), .naturalWriteAddress_i(naturalWriteAddress_i),
        .naturalWriteLine_i(naturalWriteLine_i), .naturalPid_i(naturalPid_i), .naturalTid_i(naturalTid_i),
        .outputEnable_o(outputEnable_o), .outputBundle_o(outputBundle_o),
        .bundleAddress_o(bundleAddress_o), .bundleLen_o(bundleLen_o),
        .bundlePid_o(bundlePid_o), .bundleTid_o(bundleTid_o),
        .bundleStartMajId_o(bundleStartMajId_o), .cacheMiss_o(cacheMiss_o),
        .missedAddress_o(missedAddress_o), .missedInstMajorId_o(missedInstMajorId_o),
        .missedPid_o(missedPid_o), .missedTid_o(missedTid_o)
    );

    localparam logic [19:0] PID = 20'h2A5C3;
    localparam logic [15:0] TID = 16'h1F0E;

    int nCompared = 0;
    int nMismatched = 0;

    // Reference model: a direct-mapped array of whole lines plus the fetch/miss bookkeeping.
    bit           mValid    [256];
    logic [57:0]  mLineAddr [256];
    logic [511:0] mData     [256];
    logic [63:0]  mCounter;
    logic         mMiss;
    logic [63:0]  mMissAddr, mMissId;
    logic [19:0]  mMissPid;
    logic [15:0]  mMissTid;
    logic         eOe;
    logic [127:0] eBundle;
    logic [63:0]  eAddr, eMaj;
    logic [1:0]   eLen;
    logic [19:0]  ePid;
    logic [15:0]  eTid;

    logic [511:0] patLine;

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        l = '0;
        for (int i = 0; i < 16; i++) l = {l[479:0], 32'($urandom())};
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mValid[i] = 0;
        mCounter = 0; mMiss = 0; mMissAddr = 0; mMissId = 0; mMissPid = 0; mMissTid = 0;
        eOe = 0; eBundle = 0; eAddr = 0; eMaj = 0; eLen = 0; ePid = 0; eTid = 0;
    endtask

    task automatic idle_inputs();
        fetchEnable_i = 0; fetchStall_i = 0; cacheUpdate_i = 0; naturalWriteEn_i = 0;
        Pid_i = PID; Tid_i = TID; cacheUpdatePid_i = PID; cacheUpdateTid_i = TID;
        naturalPid_i = PID; naturalTid_i = TID;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT.
    task automatic tick();
        logic         oldMiss;
        logic [7:0]   idx;
        int           n, w0;
        logic [31:0]  wv;
        oldMiss = mMiss;
        if (!fetchStall_i) begin
            if (fetchEnable_i && !oldMiss) begin
                idx = 8'(fetchAddress_i >> 6);
                if (mValid[idx] && mLineAddr[idx] == 58'(fetchAddress_i >> 6)) begin
                    w0 = int'(fetchAddress_i % 64) / 4;
                    n  = 4 - int'((fetchAddress_i / 4) % 4);
                    eBundle = 0;
                    for (int i = 0; i < 4; i++) begin
                        wv = (i < n) ? 32'(mData[idx] >> (32 * (15 - (w0 + i)))) : 32'h0;
                        eBundle = {eBundle[95:0], wv};
                    end
                    eOe = 1; eAddr = fetchAddress_i; eLen = 2'(n - 1);
                    ePid = Pid_i; eTid = Tid_i; eMaj = mCounter;
                    mCounter = mCounter + 64'(n);
                end else begin
                    eOe = 0; mMiss = 1; mMissAddr = fetchAddress_i; mMissId = mCounter;
                    mMissPid = Pid_i; mMissTid = Tid_i;
                end
            end else begin
                eOe = 0;
            end
        end
        if (cacheUpdate_i) begin
            idx = 8'(cacheUpdateAddress_i >> 6);
            mValid[idx] = 1; mLineAddr[idx] = 58'(cacheUpdateAddress_i >> 6); mData[idx] = cacheUpdateLine_i;
            mCounter = missedInstMajorId_i;
            if (oldMiss && (cacheUpdateAddress_i >> 6) == (mMissAddr >> 6)) mMiss = 0;
        end else if (naturalWriteEn_i) begin
            idx = 8'(naturalWriteAddress_i >> 6);
            mValid[idx] = 1; mLineAddr[idx] = 58'(naturalWriteAddress_i >> 6); mData[idx] = naturalWriteLine_i;
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        fetchEnable_i = 1; fetchAddress_i = 64'h1234; cacheUpdate_i = 1; naturalWriteEn_i = 1;
        cacheReset_i = 0;
        model_reset();
        #1;
        nCompared++;
        if ({outputEnable_o, outputBundle_o, bundleAddress_o, bundleLen_o, bundlePid_o, bundleTid_o,
             bundleStartMajId_o} !== '0) begin
            nMismatched++;
            $display("FAIL reset_bundle_outs: got oe=%0b bundle=%h maj=%h, want all zero",
                     outputEnable_o, outputBundle_o, bundleStartMajId_o);
        end
        nCompared++;
        if ({cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o} !== '0) begin
            nMismatched++;
            $display("FAIL reset_miss_outs: got miss=%0b addr=%h id=%h, want all zero",
                     cacheMiss_o, missedAddress_o, missedInstMajorId_o);
        end
        @(posedge clock_i); #1;
        idle_inputs();
        cacheReset_i = 1;
    endtask

    task automatic test_miss_at_zero();
        fetchEnable_i = 1; fetchAddress_i = 64'h0;
        tick();
        nCompared++;
        if (cacheMiss_o !== 1'b1 || outputEnable_o !== 1'b0 || missedAddress_o !== 64'h0) begin
            nMismatched++;
            $display("FAIL miss_at_zero: got miss=%0b oe=%0b addr=%h, want miss=1 oe=0 addr=0",
                     cacheMiss_o, outputEnable_o, missedAddress_o);
        end
        nCompared++;
        if (missedPid_o !== PID || missedTid_o !== TID || missedInstMajorId_o !== 64'd0) begin
            nMismatched++;
            $display("FAIL miss_ids: got pid=%h tid=%h id=%0d, want %h %h 0",
                     missedPid_o, missedTid_o, missedInstMajorId_o, PID, TID);
        end
        cacheReset_i = 0;
        model_reset();
        #1;
        nCompared++;
        if (cacheMiss_o !== 1'b0 || missedAddress_o !== 64'h0) begin
            nMismatched++;
            $display("FAIL reset_aborts_miss: got miss=%0b addr=%h, want 0 0", cacheMiss_o, missedAddress_o);
        end
        @(posedge clock_i); #1;
        idle_inputs();
        cacheReset_i = 1;
    endtask

    task automatic test_natural_hits();
        logic [31:0] pw [6];
        pw = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
        patLine = '0;
        for (int k = 0; k < 16; k++) patLine = {patLine[479:0], pw[k % 6]};
        for (int l = 0; l < 10; l++) begin
            naturalWriteEn_i = 1; naturalWriteAddress_i = 64'(l * 64); naturalWriteLine_i = patLine;
            tick();
            nCompared++;
            if (outputEnable_o !== 1'b0) begin
                nMismatched++;
                $display("FAIL idle_oe line=%0d: got %0b want 0", l, outputEnable_o);
            end
        end
        naturalWriteEn_i = 0;
        for (int b = 0; b < 40; b++) begin
            fetchEnable_i = 1; fetchAddress_i = 64'(b * 16);
            tick();
            nCompared++;
            if (outputEnable_o !== 1'b1 || cacheMiss_o !== 1'b0 || bundleStartMajId_o !== 64'(4 * b)
                || outputBundle_o !== eBundle || bundleAddress_o !== 64'(b * 16) || bundleLen_o !== 2'd3) begin
                nMismatched++;
                $display("FAIL hit_stream b=%0d: got oe=%0b miss=%0b maj=%0d len=%0d bundle=%h, want 1 0 %0d 3 %h",
                         b, outputEnable_o, cacheMiss_o, bundleStartMajId_o, bundleLen_o, outputBundle_o,
                         4 * b, eBundle);
            end
            if (b == 0) begin
                nCompared++;
                if (outputBundle_o !== 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD) begin
                    nMismatched++;
                    $display("FAIL bundle_at_0: got %h want AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD", outputBundle_o);
                end
            end
            if (b == 1) begin
                nCompared++;
                if (outputBundle_o !== 128'hEEEEEEEE_FFFFFFFF_AAAAAAAA_BBBBBBBB) begin
                    nMismatched++;
                    $display("FAIL bundle_at_16: got %h want EEEEEEEEFFFFFFFFAAAAAAAABBBBBBBB", outputBundle_o);
                end
            end
        end
    endtask

    task automatic test_partial_bundle();
        fetchEnable_i = 1; fetchAddress_i = 64'd8;
        tick();
        nCompared++;
        if (outputEnable_o !== 1'b1 || bundleLen_o !== 2'd1 || bundleStartMajId_o !== 64'd160
            || outputBundle_o !== 128'hCCCCCCCC_DDDDDDDD_00000000_00000000) begin
            nMismatched++;
            $display("FAIL partial_bundle: got oe=%0b len=%0d maj=%0d bundle=%h, want 1 1 160 CCCCCCCCDDDDDDDD0000000000000000",
                     outputEnable_o, bundleLen_o, bundleStartMajId_o, outputBundle_o);
        end
    endtask

    task automatic test_stall();
        fetchEnable_i = 1; fetchAddress_i = 64'd16;
        tick();
        fetchStall_i = 1; fetchAddress_i = 64'd32;
        for (int c = 0; c < 3; c++) begin
            tick();
            nCompared++;
            if (outputEnable_o !== 1'b1 || bundleStartMajId_o !== 64'd162 || bundleAddress_o !== 64'd16
                || outputBundle_o !== 128'hEEEEEEEE_FFFFFFFF_AAAAAAAA_BBBBBBBB) begin
                nMismatched++;
                $display("FAIL stall_hold c=%0d: got oe=%0b maj=%0d addr=%0d bundle=%h, want 1 162 16 EEEE..BBBB",
                         c, outputEnable_o, bundleStartMajId_o, bundleAddress_o, outputBundle_o);
            end
        end
        fetchStall_i = 0;
        tick();
        nCompared++;
        if (bundleStartMajId_o !== 64'd166 || outputBundle_o !== 128'hCCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF) begin
            nMismatched++;
            $display("FAIL after_stall: got maj=%0d bundle=%h, want 166 CCCCCCCCDDDDDDDDEEEEEEEEFFFFFFFF",
                     bundleStartMajId_o, outputBundle_o);
        end
    endtask

    task automatic test_miss_fill();
        logic [511:0] fill;
        fill = rand_line();
        fetchEnable_i = 1; fetchAddress_i = 64'd640;
        tick();
        nCompared++;
        if (cacheMiss_o !== 1'b1 || outputEnable_o !== 1'b0 || missedAddress_o !== 64'd640
            || missedInstMajorId_o !== 64'd170) begin
            nMismatched++;
            $display("FAIL miss_640: got miss=%0b oe=%0b addr=%0d id=%0d, want 1 0 640 170",
                     cacheMiss_o, outputEnable_o, missedAddress_o, missedInstMajorId_o);
        end
        fetchAddress_i = 64'd0;
        for (int c = 0; c < 2; c++) begin
            tick();
            nCompared++;
            if (cacheMiss_o !== 1'b1 || outputEnable_o !== 1'b0 || missedAddress_o !== 64'd640) begin
                nMismatched++;
                $display("FAIL fetch_ignored c=%0d: got miss=%0b oe=%0b addr=%0d, want 1 0 640",
                         c, cacheMiss_o, outputEnable_o, missedAddress_o);
            end
        end
        fetchEnable_i = 0;
        cacheUpdate_i = 1; cacheUpdateAddress_i = 64'd640; cacheUpdateLine_i = fill; missedInstMajorId_i = 64'd100;
        tick();
        cacheUpdate_i = 0;
        nCompared++;
        if (cacheMiss_o !== 1'b0) begin
            nMismatched++;
            $display("FAIL miss_cleared: got miss=%0b want 0", cacheMiss_o);
        end
        fetchEnable_i = 1; fetchAddress_i = 64'd640;
        tick();
        nCompared++;
        if (outputEnable_o !== 1'b1 || bundleStartMajId_o !== 64'd100 || outputBundle_o !== fill[511:384]) begin
            nMismatched++;
            $display("FAIL refill_hit: got oe=%0b maj=%0d bundle=%h, want 1 100 %h",
                     outputEnable_o, bundleStartMajId_o, outputBundle_o, fill[511:384]);
        end
        fetchEnable_i = 0;
    endtask

    task automatic test_write_priority();
        logic [511:0] lu, ln;
        lu = rand_line(); ln = ~lu;
        cacheUpdate_i = 1; cacheUpdateAddress_i = 64'd704; cacheUpdateLine_i = lu; missedInstMajorId_i = 64'd200;
        naturalWriteEn_i = 1; naturalWriteAddress_i = 64'd704; naturalWriteLine_i = ln;
        tick();
        cacheUpdate_i = 0; naturalWriteEn_i = 0;
        fetchEnable_i = 1; fetchAddress_i = 64'd704;
        tick();
        fetchAddress_i = 64'd720;
        tick();
        nCompared++;
        if (outputEnable_o !== 1'b1 || bundleStartMajId_o !== 64'd204 || outputBundle_o !== lu[383:256]) begin
            nMismatched++;
            $display("FAIL update_wins: got oe=%0b maj=%0d bundle=%h, want 1 204 %h",
                     outputEnable_o, bundleStartMajId_o, outputBundle_o, lu[383:256]);
        end
        fetchEnable_i = 0;
    endtask

    task automatic test_random();
        logic [294:0] gotB, expB;
        logic [164:0] gotM, expM;
        for (int c = 0; c < 400; c++) begin
            fetchEnable_i  = ($urandom_range(0, 3) != 0);
            fetchStall_i   = ($urandom_range(0, 7) == 0);
            fetchAddress_i = 64'($urandom_range(0, 8191));
            if ($urandom_range(0, 7) == 0) fetchAddress_i = fetchAddress_i | 64'h4000;
            naturalWriteEn_i = ($urandom_range(0, 3) == 0);
            naturalWriteAddress_i = 64'($urandom_range(0, 8191));
            naturalWriteLine_i = rand_line();
            cacheUpdate_i = mMiss ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            cacheUpdateAddress_i = mMiss ? (mMissAddr + 64'($urandom_range(0, 1) * 64)) : 64'($urandom_range(0, 8191));
            cacheUpdateLine_i = rand_line();
            missedInstMajorId_i = {32'($urandom()), 32'($urandom())};
            tick();
            gotB = {outputEnable_o, outputBundle_o, bundleAddress_o, bundleLen_o, bundlePid_o, bundleTid_o,
                    bundleStartMajId_o};
            expB = {eOe, eBundle, eAddr, eLen, ePid, eTid, eMaj};
            gotM = {cacheMiss_o, missedAddress_o, missedInstMajorId_o, missedPid_o, missedTid_o};
            expM = {mMiss, mMissAddr, mMissId, mMissPid, mMissTid};
            nCompared++;
            if (gotB !== expB) begin
                nMismatched++;
                $display("FAIL random_bundle c=%0d: got %h want %h", c, gotB, expB);
            end
            nCompared++;
            if (gotM !== expM) begin
                nMismatched++;
                $display("FAIL random_miss c=%0d: got %h want %h", c, gotM, expM);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_clears_valid();
        cacheReset_i = 0;
        model_reset();
        @(posedge clock_i); #1;
        cacheReset_i = 1;
        fetchEnable_i = 1; fetchAddress_i = 64'd0;
        tick();
        nCompared++;
        if (cacheMiss_o !== 1'b1 || outputEnable_o !== 1'b0 || missedInstMajorId_o !== 64'd0) begin
            nMismatched++;
            $display("FAIL valid_cleared: got miss=%0b oe=%0b id=%0d, want 1 0 0",
                     cacheMiss_o, outputEnable_o, missedInstMajorId_o);
        end
        fetchEnable_i = 0;
    endtask

    initial begin
        idle_inputs();
        fetchAddress_i = 0; cacheUpdateAddress_i = 0; naturalWriteAddress_i = 0;
        cacheUpdateLine_i = 0; naturalWriteLine_i = 0; missedInstMajorId_i = 0;
        cacheReset_i = 1;
        #2;
        test_reset();
        test_miss_at_zero();
        test_natural_hits();
        test_partial_bundle();
        test_stall();
        test_miss_fill();
        test_write_priority();
        test_random();
        test_reset_clears_valid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/l1i_cache.md
L1I_CACHE -- requirements
Module: l1i_cache

Interface
REQ-001 SHALL have parameters: fetchingAddressWidth 64 (address bits); cacheLineWith 512 (line bits); instructionWidth 32; offsetWidth 6; indexWidth 8 (256 lines); tagWidth = fetchingAddressWidth-indexWidth-offsetWidth; PidSize 20; TidSize 16; instructionCounterWidth 64.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clock_i  in  1  clock.
- cacheReset_i  in  1  async active-low reset.
REQ-003 SHALL have these fetch-input ports:
- fetchEnable_i  in  1  fetch request.
- fetchStall_i  in  1  hold outputs.
- Pid_i/Tid_i  in  PidSize/TidSize  requester ids.
- fetchAddress_i  in  64  fetch byte address.
REQ-004 SHALL have these miss-update input ports:
- cacheUpdate_i  in  1  miss fill strobe.
- cacheUpdateAddress_i  in  64  fill address.
- cacheUpdatePid_i/cacheUpdateTid_i  in  fill ids.
- missedInstMajorId_i  in  64  resume ID.
- cacheUpdateLine_i  in  512  fill line.
REQ-005 SHALL have these natural-write input ports:
- naturalWriteEn_i  in  1.
- naturalWriteAddress_i  in  64.
- naturalWriteLine_i  in  512.
- naturalPid_i/naturalTid_i  in  ids.
REQ-006 SHALL have these bundle output ports:
- outputEnable_o  1.
- outputBundle_o  128.
- bundleAddress_o  64.
- bundleLen_o  2.
- bundlePid_o/bundleTid_o.
- bundleStartMajId_o  64.
REQ-007 SHALL have these miss output ports:
- cacheMiss_o  1.
- missedAddress_o  64.
- missedInstMajorId_o  64.
- missedPid_o/missedTid_o.

Function
REQ-008 SHALL be direct-mapped, 256 lines of 64 bytes; big-endian bit numbering; index = addr[50:57], tag = addr[0:49], bundle select = addr[58:59], word = addr[60:61].
REQ-009 SHALL, on a clock edge with fetchEnable_i=1, fetchStall_i=0 and no pending miss, look up the line and register its result (one-cycle latency).
REQ-010 SHALL, on a hit (valid and tag equal), set outputEnable_o=1 and cacheMiss_o=0, and present the following; instruction 0 is in bits [0:31]:
- outputBundle_o: the instruction words from word addr[60:61] to the end of the 16-byte bundle.
- Unused words: zero.
- bundleLen_o: word count minus 1.
- bundleAddress_o: the fetch address.
- bundlePid_o/bundleTid_o: Pid_i/Tid_i.
REQ-011 SHALL, on a hit, output the internal 64-bit ID counter on bundleStartMajId_o, then advance the counter by the bundle's instruction count.
REQ-012 SHALL, on a miss, do all of the following:
- Set outputEnable_o=0 and cacheMiss_o=1.
- Capture missedAddress_o, missedPid_o, missedTid_o and missedInstMajorId_o (counter).
- Ignore fetches until cleared.
REQ-013 SHALL, on a clock edge with cacheUpdate_i=1, write cacheUpdateLine_i and its tag/ids into the line at cacheUpdateAddress_i, set it valid, and load the ID counter from missedInstMajorId_i. If the address matches the missed line it SHALL also clear cacheMiss_o, with fetching resuming next cycle.
REQ-014 SHALL, on a clock edge with naturalWriteEn_i=1, write naturalWriteLine_i at index/tag of naturalWriteAddress_i and set it valid; it never touches the miss state.
REQ-015 SHALL give cacheUpdate_i priority when both writes occur in one cycle; the natural write is dropped.
REQ-016 SHALL give read-before-write semantics when a fetch and a write hit the same index in one cycle: the fetch sees the old contents.
REQ-017 SHALL hold all outputs unchanged while fetchStall_i=1 and not advance the counter.
REQ-018 SHALL drive outputEnable_o=0 on cycles with fetchEnable_i=0; miss outputs persist until cleared.

Reset
REQ-019 SHALL, while cacheReset_i=0, perform all of the following:
- Clear all valid bits.
- Clear the ID counter.
- Drive every output to 0.
- Clear the miss state.
REQ-020 SHALL abort any outstanding miss when reset is asserted mid-miss.

Configuration
REQ-021 SHALL implement the macro L1I_PID_TID_CHECK_EN as follows:
- Defined: line ids are stored and a hit also requires stored Pid/Tid equal to Pid_i/Tid_i.
- Undefined: ids are not stored and a hit requires valid and tag only.

Structure
REQ-022 SHALL place the width constants, the 128-bit bundle typedef and the address-field slice constants in package l1i_cache_pkg.
REQ-023 SHALL implement the tag/valid/data storage as sub-module l1i_line_array, which has 1 read port and 1 write port.

Verification
REQ-024 SHALL cover: reset, then fetch at 0x0 -> cacheMiss_o=1, missedAddress_o=0.
REQ-025 SHALL cover: natural-write 10 lines at 0,64,…,576, each with pattern AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD_EEEEEEEE_FFFFFFFF repeating, then fetch 40 bundles at 16-byte steps -> all hits. Required values:
- Address 0: bundle AAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD, bundleLen_o=3.
- Address 16: bundle EEEEEEEE_FFFFFFFF_AAAAAAAA_BBBBBBBB.
- bundleStartMajId_o steps by 4.
REQ-026 SHALL cover: after those writes, fetch 640 -> cacheMiss_o=1, missedAddress_o=640; later fetches ignored; cacheUpdate at 640 with missedInstMajorId_i=100 -> next fetch 640 hits with bundleStartMajId_o=100.
REQ-027 SHALL cover: fetch at address 8 after the writes -> bundleLen_o=1, bundle CCCCCCCC_DDDDDDDD_00000000_00000000.
REQ-028 SHALL cover: fetchStall_i=1 for 3 cycles mid-stream -> outputs frozen, counter unchanged.
REQ-029 SHALL cover: cacheUpdate_i and naturalWriteEn_i to the same index in one cycle -> the update line wins.
